// File: rtl/csa_pkg.sv
`timescale 1ns / 1ps
// Shared types and helpers for the carry-save resolver.
//   state_e      : resolver FSM states
//   DefaultW     : default operand width
//   DefaultChunk : default bits added per cycle
//   chunk_count  : number of add cycles for a given width and chunk size
//   idx_width    : width of the chunk index counter (at least 1 bit)
package csa_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  localparam int unsigned DefaultW     = 32;
  localparam int unsigned DefaultChunk = 8;

  function automatic int unsigned chunk_count(input int unsigned w, input int unsigned chunk);
    return w / chunk;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
`timescale 1ns / 1ps
// Purely combinational CHUNK-bit adder with carry in and carry out.
//   a, b : addends
//   cin  : carry in
//   s    : CHUNK-bit sum
//   cout : carry out of the top bit
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/csa_resolver.sv
`timescale 1ns / 1ps
// Multi-cycle carry-save to binary resolver.
// Latches one (sum, carry) pair, adds it CHUNK bits per cycle with a registered
// inter-chunk carry, then holds the W+2 bit binary result until it is taken.
//   clk_100mhz : clock, rising edge
//   reset      : asynchronous active-high reset
//   s_valid    : input pair valid
//   s_ready    : resolver idle and able to accept a pair
//   s_sum      : sum vector, bit i weight 2^i
//   s_carry    : carry vector, bit i weight 2^(i+1)
//   m_valid    : result valid
//   m_ready    : downstream takes the result
//   m_data     : s_sum + 2*s_carry
module csa_resolver
  import csa_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic         clk_100mhz,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_sum,
  input  logic [W-1:0] s_carry,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W+1:0] m_data
);

  localparam int unsigned N    = chunk_count(W, CHUNK);
  localparam int unsigned IdxW = idx_width(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  if ((W % CHUNK) != 0 || W < CHUNK) begin : g_bad_params
    $fatal(1, "csa_resolver: W must be a non-zero multiple of CHUNK");
  end

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            cy_q, cy_d;
  // Operands are W+1 bits: A = {0, sum}, B = {carry, 0}.
  logic [W:0]      a_q, a_d;
  logic [W:0]      b_q, b_d;
  logic [W+1:0]    data_q, data_d;

  logic [31:0]      chunk_off;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout;

  // Select the chunk currently being added.
  always_comb begin
    chunk_off = 32'(idx_q) * CHUNK;
    chunk_a   = a_q[chunk_off +: CHUNK];
    chunk_b   = b_q[chunk_off +: CHUNK];
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (cy_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  // FSM state register.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (s_valid) state_d = StAdd;
      StAdd:  if (idx_q == LastIdx) state_d = StDone;
      StDone: if (m_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    s_ready = (state_q == StIdle);
    m_valid = (state_q == StDone);
  end

  // Datapath next state.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    idx_d  = idx_q;
    cy_d   = cy_q;
    data_d = data_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          a_d   = {1'b0, s_sum};
          b_d   = {s_carry, 1'b0};
          idx_d = '0;
          cy_d  = 1'b0;
        end
      end
      StAdd: begin
        data_d[chunk_off +: CHUNK] = chunk_s;
        cy_d  = chunk_cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // Top operand bits plus the final chunk carry fill the two MSBs.
          data_d[W+1:W] = {1'b0, a_q[W]} + {1'b0, b_q[W]} + {1'b0, chunk_cout};
          idx_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      cy_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      cy_q   <= cy_d;
      a_q    <= a_d;
      b_q    <= b_d;
      data_q <= data_d;
    end
  end

  assign m_data = data_q;

endmodule
